// File: rtl/axi_mem_slave.sv
// AXI4 INCR-only slave over a 2^DEPTH_LOG2 x DATA_WIDTH simple dual-port array.
// Build option AXI_MEM_SLAVE_DECERR_EN: start addresses outside the array answer DECERR.

module axi_mem_slave #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 29,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_LO = 5;
    localparam int IDX_HI = DEPTH_LOG2 + 4;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];

    logic                  ready_en_q;

    logic [1:0]            w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q,    w_id_d;
    logic [DEPTH_LOG2-1:0] w_idx_q,   w_idx_d;
    logic [7:0]            w_len_q,   w_len_d;
    logic [7:0]            w_cnt_q,   w_cnt_d;
    logic                  w_err_q,   w_err_d;
    logic                  w_dec_q,   w_dec_d;

    logic [1:0]            r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q,    r_id_d;
    logic [DEPTH_LOG2-1:0] r_idx_q,   r_idx_d;
    logic [7:0]            r_len_q,   r_len_d;
    logic [7:0]            r_cnt_q,   r_cnt_d;
    logic                  r_dec_q,   r_dec_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;

    logic aw_hs_s, ar_hs_s, w_last_s, r_last_s, mem_we_s;
    logic aw_dec_s, ar_dec_s;
    logic unused_s;

`ifdef AXI_MEM_SLAVE_DECERR_EN
    assign aw_dec_s = |s_axi_awaddr[ADDR_WIDTH-1:IDX_HI+1];
    assign ar_dec_s = |s_axi_araddr[ADDR_WIDTH-1:IDX_HI+1];
`else
    assign aw_dec_s = 1'b0;
    assign ar_dec_s = 1'b0;
`endif

    // Size/burst are ignored and sub-beat address bits never select anything.
    assign unused_s = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                        s_axi_awaddr[IDX_LO-1:0], s_axi_araddr[IDX_LO-1:0],
                        s_axi_awaddr[ADDR_WIDTH-1:IDX_HI+1], s_axi_araddr[ADDR_WIDTH-1:IDX_HI+1]};

    assign aw_hs_s  = s_axi_awvalid & s_axi_awready;
    assign ar_hs_s  = s_axi_arvalid & s_axi_arready;
    assign w_last_s = (w_cnt_q == w_len_q);
    assign r_last_s = (r_cnt_q == r_len_q);

    assign s_axi_awready = ready_en_q & (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bid     = w_id_q;
    assign s_axi_bresp   = (w_state_q != W_RESP) ? 2'b00 :
                           w_dec_q               ? 2'b11 :
                           w_err_q               ? 2'b10 : 2'b00;

    assign s_axi_arready = ready_en_q & (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rid     = r_id_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = ((r_state_q == R_DATA) && r_dec_q) ? 2'b11 : 2'b00;
    assign s_axi_rlast   = (r_state_q == R_DATA) & r_last_s;

    // Ready gate: held low through reset and released on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Write channel next state: AW latch, beat counting, wlast check, response.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_dec_d   = w_dec_q;
        mem_we_s  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    w_id_d    = s_axi_awid;
                    w_idx_d   = s_axi_awaddr[IDX_HI:IDX_LO];
                    w_len_d   = s_axi_awlen;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    w_dec_d   = aw_dec_s;
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    mem_we_s  = ~w_dec_q;
                    w_idx_d   = w_idx_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
                    w_cnt_d   = w_cnt_q + 8'd1;
                    w_err_d   = w_err_q | (s_axi_wlast != w_last_s);
                    w_state_d = w_last_s ? W_RESP : W_DATA;
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_err_d   = 1'b0;
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Write channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            w_id_q    <= {ID_WIDTH{1'b0}};
            w_idx_q   <= {DEPTH_LOG2{1'b0}};
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_err_q   <= 1'b0;
            w_dec_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            w_dec_q   <= w_dec_d;
        end
    end

    // Byte-enabled array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read channel next state: AR latch, one-cycle fetch, hold beat until rready.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_dec_d   = r_dec_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_id_d    = s_axi_arid;
                    r_idx_d   = s_axi_araddr[IDX_HI:IDX_LO];
                    r_len_d   = s_axi_arlen;
                    r_cnt_d   = 8'd0;
                    r_dec_d   = ar_dec_s;
                    r_state_d = R_FETCH;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_FETCH: begin
                rdata_d   = r_dec_q ? {DATA_WIDTH{1'b0}} : mem_q[r_idx_q];
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (r_last_s) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d   = r_idx_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_state_d = R_FETCH;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Read channel state registers, including the registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            r_id_q    <= {ID_WIDTH{1'b0}};
            r_idx_q   <= {DEPTH_LOG2{1'b0}};
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            r_dec_q   <= 1'b0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_dec_q   <= r_dec_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomised self-checking bench for axi_mem_slave against a byte-level memory model.
// Honours AXI_MEM_SLAVE_DECERR_EN so the same bench covers both builds.

module tb_axi_mem_slave;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   s_axi_awid = 4'd0;
    logic [28:0]  s_axi_awaddr = 29'd0;
    logic [7:0]   s_axi_awlen = 8'd0;
    logic [2:0]   s_axi_awsize = 3'd0;
    logic [1:0]   s_axi_awburst = 2'd0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [255:0] s_axi_wdata = 256'd0;
    logic [31:0]  s_axi_wstrb = 32'd0;
    logic         s_axi_wlast = 1'b0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [3:0]   s_axi_bid;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b0;
    logic [3:0]   s_axi_arid = 4'd0;
    logic [28:0]  s_axi_araddr = 29'd0;
    logic [7:0]   s_axi_arlen = 8'd0;
    logic [2:0]   s_axi_arsize = 3'd0;
    logic [1:0]   s_axi_arburst = 2'd0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [3:0]   s_axi_rid;
    logic [255:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;

    axi_mem_slave dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [255:0] ref_mem [1024];

    // Observations gathered by the bus drivers
    logic         w_rdy_after_aw;
    logic         b_now;
    logic [1:0]   b_resp_o;
    logic [3:0]   b_id_o;
    logic [255:0] rd_data[$];
    logic [1:0]   rd_resp[$];
    logic         rd_last[$];
    logic [3:0]   rd_id[$];
    int           rd_lat[$];
    logic         stall_changed;

    function automatic logic dec_of(input logic [28:0] a);
`ifdef AXI_MEM_SLAVE_DECERR_EN
        return (a >= 29'h8000);
`else
        return (a != a);
`endif
    endfunction

    function automatic int idx_of(input logic [28:0] a, input int b);
        return (int'(a / 29'd32) + b) % 1024;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [28:0] addr, input int len, input logic [3:0] id,
                               input int bad_beat, input int strb_beat, input logic [31:0] strb_val,
                               input logic fixed, input logic [255:0] fdata);
        int n;
        logic [255:0] d;
        logic [31:0] s;
        logic dec;
        dec = dec_of(addr);
        s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awid = id;
        s_axi_awsize = 3'd5; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 50) begin tick(); n++; end
        if (!s_axi_awready) begin
            total++; bad++; $display("FAIL aw_timeout: awready=%b want 1", s_axi_awready);
            s_axi_awvalid = 1'b0; return;
        end
        tick();
        s_axi_awvalid = 1'b0;
        w_rdy_after_aw = s_axi_wready;
        for (int b = 0; b <= len; b++) begin
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
            if (fixed) d = fdata;
            s = (b == strb_beat) ? strb_val : 32'hFFFF_FFFF;
            s_axi_wdata = d; s_axi_wstrb = s;
            s_axi_wlast = (bad_beat >= 0) ? (b == bad_beat) : (b == len);
            s_axi_wvalid = 1'b1;
            n = 0;
            while (!s_axi_wready && n < 50) begin tick(); n++; end
            if (!s_axi_wready) begin
                total++; bad++; $display("FAIL w_timeout: wready=%b want 1 beat %0d", s_axi_wready, b);
                s_axi_wvalid = 1'b0; return;
            end
            if (!dec) for (int k = 0; k < 32; k++) if (s[k]) ref_mem[idx_of(addr, b)][k*8 +: 8] = d[k*8 +: 8];
            tick();
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        b_now = s_axi_bvalid;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin tick(); n++; end
        if (!s_axi_bvalid) begin
            total++; bad++; $display("FAIL b_timeout: bvalid=%b want 1", s_axi_bvalid); return;
        end
        b_resp_o = s_axi_bresp; b_id_o = s_axi_bid;
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic read_burst(input logic [28:0] addr, input int len, input logic [3:0] id,
                              input int stall_beat, input int stall_cyc);
        int n;
        rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_id.delete(); rd_lat.delete();
        stall_changed = 1'b0;
        s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arid = id;
        s_axi_arsize = 3'd5; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        s_axi_rready = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 50) begin tick(); n++; end
        if (!s_axi_arready) begin
            total++; bad++; $display("FAIL ar_timeout: arready=%b want 1", s_axi_arready);
            s_axi_arvalid = 1'b0; s_axi_rready = 1'b0; return;
        end
        tick();
        s_axi_arvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            n = 0;
            while (!s_axi_rvalid && n < 50) begin tick(); n++; end
            if (!s_axi_rvalid) begin
                total++; bad++; $display("FAIL r_timeout: rvalid=%b want 1 beat %0d", s_axi_rvalid, b);
                s_axi_rready = 1'b0; return;
            end
            rd_data.push_back(s_axi_rdata); rd_resp.push_back(s_axi_rresp);
            rd_last.push_back(s_axi_rlast); rd_id.push_back(s_axi_rid); rd_lat.push_back(n);
            if (b == stall_beat) begin
                s_axi_rready = 1'b0;
                for (int c = 0; c < stall_cyc; c++) begin
                    tick();
                    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== rd_data[b] || s_axi_rid !== rd_id[b] ||
                        s_axi_rlast !== rd_last[b] || s_axi_rresp !== rd_resp[b]) stall_changed = 1'b1;
                end
                s_axi_rready = 1'b1;
            end
            tick();
        end
        s_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: aw/ar/w/b/rv/rl=%b want 000000",
                {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast}); end
        total++; if ({s_axi_rdata, s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid} !== 268'd0) begin
            bad++; $display("FAIL reset_data: rdata=%h bresp=%b rresp=%b want 0", s_axi_rdata, s_axi_bresp, s_axi_rresp); end
        rst_n = 1'b1;
        #3;
        total++; if ({s_axi_awready, s_axi_arready} !== 2'b00) begin
            bad++; $display("FAIL ready_first_cycle: aw/ar=%b want 00", {s_axi_awready, s_axi_arready}); end
        tick();
        total++; if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
            bad++; $display("FAIL ready_second_edge: aw/ar=%b want 11", {s_axi_awready, s_axi_arready}); end
    endtask

    task automatic test_single();
        logic [255:0] pat;
        pat = {32{8'hA5}};
        write_burst(29'h40, 0, 4'h3, -1, -1, 32'h0, 1'b1, pat);
        total++; if (w_rdy_after_aw !== 1'b1) begin bad++; $display("FAIL wready_latency: got %b want 1", w_rdy_after_aw); end
        total++; if (b_now !== 1'b1) begin bad++; $display("FAIL bvalid_latency: got %b want 1", b_now); end
        total++; if (b_resp_o !== 2'b00) begin bad++; $display("FAIL single_bresp: got %b want 00", b_resp_o); end
        total++; if (b_id_o !== 4'h3) begin bad++; $display("FAIL single_bid: got %h want 3", b_id_o); end
        read_burst(29'h40, 0, 4'h5, -1, 0);
        total++; if (rd_data.size() !== 1) begin bad++; $display("FAIL single_beats: got %0d want 1", rd_data.size()); end
        if (rd_data.size() == 1) begin
            total++; if (rd_data[0] !== pat) begin bad++; $display("FAIL single_rdata: got %h want %h", rd_data[0], pat); end
            total++; if (rd_last[0] !== 1'b1) begin bad++; $display("FAIL single_rlast: got %b want 1", rd_last[0]); end
            total++; if (rd_resp[0] !== 2'b00) begin bad++; $display("FAIL single_rresp: got %b want 00", rd_resp[0]); end
            total++; if (rd_id[0] !== 4'h5) begin bad++; $display("FAIL single_rid: got %h want 5", rd_id[0]); end
            total++; if (rd_lat[0] !== 1) begin bad++; $display("FAIL single_rvalid_latency: waited %0d want 1", rd_lat[0]); end
        end
    endtask

    task automatic test_burst_strobe();
        logic [255:0] before2;
        write_burst(29'h0, 3, 4'h1, -1, -1, 32'h0, 1'b0, 256'd0);
        before2 = ref_mem[2];
        write_burst(29'h0, 3, 4'h2, -1, 2, 32'h0000_000F, 1'b0, 256'd0);
        total++; if (b_resp_o !== 2'b00) begin bad++; $display("FAIL strobe_bresp: got %b want 00", b_resp_o); end
        read_burst(29'h0, 3, 4'h6, -1, 0);
        total++; if (rd_data.size() !== 4) begin bad++; $display("FAIL strobe_beats: got %0d want 4", rd_data.size()); end
        for (int b = 0; b < rd_data.size(); b++) begin
            total++; if (rd_data[b] !== ref_mem[b]) begin bad++; $display("FAIL strobe_rdata[%0d]: got %h want %h", b, rd_data[b], ref_mem[b]); end
            total++; if (rd_last[b] !== (b == 3)) begin bad++; $display("FAIL strobe_rlast[%0d]: got %b", b, rd_last[b]); end
            total++; if (rd_lat[b] !== 1) begin bad++; $display("FAIL strobe_lat[%0d]: waited %0d want 1", b, rd_lat[b]); end
        end
        if (rd_data.size() == 4) begin
            total++; if (rd_data[2][255:32] !== before2[255:32]) begin
                bad++; $display("FAIL strobe_untouched: got %h want %h", rd_data[2][255:32], before2[255:32]); end
        end
    endtask

    task automatic test_backpressure();
        write_burst(29'd100 * 29'd32, 2, 4'h4, -1, -1, 32'h0, 1'b0, 256'd0);
        read_burst(29'd100 * 29'd32, 2, 4'hA, 0, 5);
        total++; if (stall_changed !== 1'b0) begin bad++; $display("FAIL stall_stable: changed=%b want 0", stall_changed); end
        total++; if (rd_data.size() !== 3) begin bad++; $display("FAIL bp_beats: got %0d want 3", rd_data.size()); end
        for (int b = 0; b < rd_data.size(); b++) begin
            total++; if (rd_data[b] !== ref_mem[100 + b]) begin bad++; $display("FAIL bp_rdata[%0d]: got %h want %h", b, rd_data[b], ref_mem[100 + b]); end
            total++; if (rd_last[b] !== (b == 2)) begin bad++; $display("FAIL bp_rlast[%0d]: got %b", b, rd_last[b]); end
            total++; if (rd_id[b] !== 4'hA) begin bad++; $display("FAIL bp_rid[%0d]: got %h want a", b, rd_id[b]); end
        end
    endtask

    task automatic test_wlast_err();
        write_burst(29'd200 * 29'd32, 1, 4'h7, 0, -1, 32'h0, 1'b0, 256'd0);
        total++; if (b_resp_o !== 2'b10) begin bad++; $display("FAIL wlast_early: got %b want 10", b_resp_o); end
        total++; if (b_id_o !== 4'h7) begin bad++; $display("FAIL wlast_bid: got %h want 7", b_id_o); end
        write_burst(29'd210 * 29'd32, 0, 4'h8, 9, -1, 32'h0, 1'b0, 256'd0);
        total++; if (b_resp_o !== 2'b10) begin bad++; $display("FAIL wlast_missing: got %b want 10", b_resp_o); end
        write_burst(29'd220 * 29'd32, 1, 4'h9, -1, -1, 32'h0, 1'b0, 256'd0);
        total++; if (b_resp_o !== 2'b00) begin bad++; $display("FAIL wlast_clean_after: got %b want 00", b_resp_o); end
        read_burst(29'd200 * 29'd32, 1, 4'h1, -1, 0);
        for (int b = 0; b < rd_data.size(); b++) begin
            total++; if (rd_data[b] !== ref_mem[200 + b]) begin bad++; $display("FAIL wlast_data[%0d]: got %h want %h", b, rd_data[b], ref_mem[200 + b]); end
        end
    endtask

    task automatic test_reset_abort();
        logic [255:0] d;
        write_burst(29'd8 * 29'd32, 3, 4'h2, -1, -1, 32'h0, 1'b0, 256'd0);
        s_axi_awaddr = 29'd8 * 29'd32; s_axi_awlen = 8'd3; s_axi_awid = 4'hC; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
        s_axi_wdata = d; s_axi_wstrb = 32'hFFFF_FFFF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
        total++; if (s_axi_wready !== 1'b1) begin bad++; $display("FAIL abort_wready: got %b want 1", s_axi_wready); end
        ref_mem[8] = d;
        tick();
        s_axi_wvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({s_axi_wready, s_axi_bvalid, s_axi_awready} !== 3'b000) begin
            bad++; $display("FAIL abort_outputs: w/b/aw=%b want 000", {s_axi_wready, s_axi_bvalid, s_axi_awready}); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (s_axi_bvalid !== 1'b0) begin bad++; $display("FAIL abort_no_resp: got %b want 0", s_axi_bvalid); end
        read_burst(29'd8 * 29'd32, 3, 4'h3, -1, 0);
        total++; if (rd_data.size() !== 4) begin bad++; $display("FAIL abort_beats: got %0d want 4", rd_data.size()); end
        for (int b = 0; b < rd_data.size(); b++) begin
            total++; if (rd_data[b] !== ref_mem[8 + b]) begin bad++; $display("FAIL abort_data[%0d]: got %h want %h", b, rd_data[b], ref_mem[8 + b]); end
        end
    endtask

    task automatic test_alias();
        logic [28:0] hi;
        logic dec;
        hi = 29'h8000;
        dec = dec_of(hi);
        write_burst(29'h0, 0, 4'h1, -1, -1, 32'h0, 1'b0, 256'd0);
        write_burst(hi, 0, 4'hE, -1, -1, 32'h0, 1'b0, 256'd0);
        total++; if (b_resp_o !== (dec ? 2'b11 : 2'b00)) begin bad++; $display("FAIL alias_bresp: got %b want %b", b_resp_o, dec ? 2'b11 : 2'b00); end
        read_burst(hi, 0, 4'hD, -1, 0);
        if (rd_data.size() == 1) begin
            total++; if (rd_data[0] !== (dec ? 256'd0 : ref_mem[0])) begin bad++; $display("FAIL alias_rdata: got %h", rd_data[0]); end
            total++; if (rd_resp[0] !== (dec ? 2'b11 : 2'b00)) begin bad++; $display("FAIL alias_rresp: got %b want %b", rd_resp[0], dec ? 2'b11 : 2'b00); end
        end
        read_burst(29'h0, 0, 4'h2, -1, 0);
        if (rd_data.size() == 1) begin
            total++; if (rd_data[0] !== ref_mem[0]) begin bad++; $display("FAIL alias_index0: got %h want %h", rd_data[0], ref_mem[0]); end
            total++; if (rd_resp[0] !== 2'b00) begin bad++; $display("FAIL alias_index0_rresp: got %b want 00", rd_resp[0]); end
        end
    endtask

    task automatic test_back_to_back();
        write_burst(29'd300 * 29'd32, 3, 4'h5, -1, -1, 32'h0, 1'b0, 256'd0);
        total++; if ({s_axi_awready, s_axi_arready} !== 2'b11) begin bad++; $display("FAIL both_ready: got %b want 11", {s_axi_awready, s_axi_arready}); end
        fork
            write_burst(29'd400 * 29'd32, 3, 4'h6, -1, -1, 32'h0, 1'b0, 256'd0);
            read_burst(29'd300 * 29'd32, 3, 4'h7, -1, 0);
        join
        total++; if (b_resp_o !== 2'b00) begin bad++; $display("FAIL b2b_bresp: got %b want 00", b_resp_o); end
        for (int b = 0; b < rd_data.size(); b++) begin
            total++; if (rd_data[b] !== ref_mem[300 + b]) begin bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", b, rd_data[b], ref_mem[300 + b]); end
        end
        read_burst(29'd400 * 29'd32, 3, 4'h8, -1, 0);
        for (int b = 0; b < rd_data.size(); b++) begin
            total++; if (rd_data[b] !== ref_mem[400 + b]) begin bad++; $display("FAIL b2b_wdata[%0d]: got %h want %h", b, rd_data[b], ref_mem[400 + b]); end
        end
    endtask

    task automatic test_random();
        logic [28:0] a;
        int len, ix;
        for (int t = 0; t < 7; t++) begin
            if (t == 6) begin a = 29'd1020 * 29'd32; len = 255; end
            else begin a = 29'($urandom_range(0, 1023)) * 29'd32; len = $urandom_range(0, 15); end
            write_burst(a, len, 4'($urandom()), -1, -1, 32'h0, 1'b0, 256'd0);
            total++; if (b_resp_o !== 2'b00) begin bad++; $display("FAIL rand_bresp[%0d]: got %b want 00", t, b_resp_o); end
            read_burst(a, len, 4'(t), -1, 0);
            total++; if (rd_data.size() !== len + 1) begin bad++; $display("FAIL rand_beats[%0d]: got %0d want %0d", t, rd_data.size(), len + 1); end
            for (int b = 0; b < rd_data.size(); b++) begin
                ix = idx_of(a, b);
                total++; if (rd_data[b] !== ref_mem[ix]) begin bad++; $display("FAIL rand_rdata[%0d.%0d]: got %h want %h", t, b, rd_data[b], ref_mem[ix]); end
                total++; if (rd_last[b] !== (b == len)) begin bad++; $display("FAIL rand_rlast[%0d.%0d]: got %b", t, b, rd_last[b]); end
                total++; if (rd_id[b] !== 4'(t)) begin bad++; $display("FAIL rand_rid[%0d.%0d]: got %h want %h", t, b, rd_id[b], 4'(t)); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst_strobe();
        test_backpressure();
        test_wlast_err();
        test_reset_abort();
        test_alias();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
